fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, boot fetch address.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned read address; bits [1:0] always 0.
REQ-006 imem_ready  input  1  memory returns data this cycle; meaningful only while imem_req=1.
REQ-007 imem_rdata  input  32  read data; sampled only when imem_req=1 and imem_ready=1.
REQ-008 instr_valid  output  1  held instruction is valid for the decode stage.
REQ-009 instr_ready  input  1  decode stage accepts the held instruction this cycle.
REQ-010 instr  output  32  held instruction word.
REQ-011 op  output  6  instr[31:26], opcode to the decoder.
REQ-012 func  output  4  instr[3:0], function field to the decoder.
REQ-013 pc  output  32  address of the held instruction.
REQ-014 jump  input  1  decoder jump flag for the held instruction; ignored unless instr_valid=1 and instr_ready=1.
REQ-015 fetch_count  output  16  number of instructions accepted by decode since reset.

Function
REQ-016 FSM has three states: IDLE, FETCH and HOLD.
REQ-017 IDLE is entered on reset; the first rising edge after rst_n deasserts moves the FSM to FETCH.
REQ-018 In FETCH, imem_req=1 and imem_addr=fetch_addr; no other state asserts imem_req.
REQ-019 Once asserted, imem_req and imem_addr stay stable until a cycle with imem_ready=1; there is no timeout.
REQ-020 When imem_ready=1 in FETCH, the block latches imem_rdata into instr and fetch_addr into pc, then enters HOLD on the next edge.
REQ-021 instr_valid=1 exactly while in HOLD; instr, op, func and pc stay constant throughout HOLD.
REQ-022 In HOLD with instr_ready=0, the block stays in HOLD with no change.
REQ-023 In HOLD with instr_ready=1 and jump=0, fetch_addr becomes pc+4, with modulo-2^32 wrap (32'hFFFF_FFFC -> 32'h0000_0000), and the FSM enters FETCH.
REQ-024 In HOLD with instr_ready=1 and jump=1, fetch_addr becomes {pc_plus4[31:28], instr[25:0], 2'b00}, where pc_plus4 is the wrapped pc+4, and the FSM enters FETCH.
REQ-025 Each HOLD-state acceptance increments fetch_count by 1, wrapping from 16'hFFFF to 0.
REQ-026 jump and instr_ready are ignored outside HOLD; imem_ready and imem_rdata are ignored outside FETCH.
REQ-027 Latency:
- FETCH with imem_ready=1 gives instr_valid=1 on the next cycle.
- Acceptance in HOLD gives imem_req=1 on the next cycle.
- Peak throughput is one instruction per 2 cycles.
REQ-028 A memory that is ready in the same cycle as the request incurs no extra wait cycle; each cycle of imem_ready=0 adds exactly one cycle.

Reset
REQ-029 rst_n=0 forces the following immediately, regardless of clk:
- state=IDLE
- fetch_addr=RESET_PC, pc=RESET_PC
- instr=0, hence op=0, func=0
- instr_valid=0, imem_req=0, fetch_count=0
REQ-030 Reset in FETCH drops the pending request without waiting for imem_ready.
REQ-031 Reset in HOLD discards the held instruction; no acceptance is counted.
REQ-032 After rst_n rises, the first request is issued to RESET_PC on the second rising edge.

Verification
REQ-033 Bench shall cover the following directed scenarios:
- Boot: release reset, memory always ready, rdata=32'h2000_0000 -> imem_addr=0, then instr_valid=1 with op=6'b001000 and pc=0; on acceptance the next imem_addr=4.
- Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr, pc and instr_valid held constant, imem_req=0, fetch_count unchanged; on acceptance fetch_count increments by 1.
- Memory wait: imem_ready=0 for 3 cycles -> imem_req=1 with a stable address for 4 cycles; instr_valid rises on the cycle after imem_ready=1.
- Jump: pc=32'h4000_0010, instr=32'h0800_0040, jump=1, accepted -> next imem_addr=32'h4000_0100.
- Wrap: pc=32'hFFFF_FFFC, accepted with jump=0 -> next imem_addr=0.
- Mid-fetch reset: rst_n=0 asynchronously while imem_req=1 -> imem_req=0, instr_valid=0, pc=RESET_PC, fetch_count=0 within the same cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word-aligned read at a time, holds the returned
// instruction for decode, and computes the next fetch address (sequential or jump).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [3:0]  func,
  output logic [31:0] pc,
  input  logic        jump,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] count_q, count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    count_d      = count_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          pc_d    = fetch_addr_q;
          state_d = StHold;
        end
      end
      StHold: begin
        if (instr_ready) begin
          count_d      = count_q + 16'd1;
          // Jump keeps the top nibble of the sequential successor.
          fetch_addr_d = jump ? {pc_plus4[31:28], instr_q[25:0], 2'b00} : pc_plus4;
          state_d      = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fetch_addr_q <= RESET_PC;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      count_q      <= 16'h0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      count_q      <= count_d;
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = {fetch_addr_q[31:2], 2'b00};
  assign instr_valid = (state_q == StHold);
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign func        = instr_q[3:0];
  assign pc          = pc_q;
  assign fetch_count = count_q;

endmodule
